// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection and registered EX forward selects.
// Optional `WB_BYPASS_EN: forward the WB write port into the captured register-file operands.
module id_ex_stage_reg #(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_in,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [DW-1:0]    id_pc_next,
    input  logic [DW-1:0]    id_read_data1,
    input  logic [DW-1:0]    id_read_data2,
    input  logic [DW-1:0]    id_imm,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic [AW-1:0]    id_write_addr,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic [1:0]       id_memtoreg,
    input  logic [3:0]       id_aluctrl,
    input  logic             mem_regwrite,
    input  logic [AW-1:0]    mem_write_addr,
    input  logic             wb_regwrite,
    input  logic [AW-1:0]    wb_write_addr,
    input  logic [DW-1:0]    wb_write_data,
    output logic             load_use_stall,
    output logic             ex_valid,
    output logic [DW-1:0]    ex_pc_next,
    output logic [DW-1:0]    ex_read_data1,
    output logic [DW-1:0]    ex_read_data2,
    output logic [DW-1:0]    ex_imm,
    output logic [AW-1:0]    ex_rs,
    output logic [AW-1:0]    ex_rt,
    output logic [AW-1:0]    ex_write_addr,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic [1:0]       ex_memtoreg,
    output logic [3:0]       ex_aluctrl,
    output logic [1:0]       ex_forward_a,
    output logic [1:0]       ex_forward_b,
    output logic [CNT_W-1:0] load_use_count
);

    localparam logic [1:0] FwdReg = 2'b00;
    localparam logic [1:0] FwdEx  = 2'b01;
    localparam logic [1:0] FwdMem = 2'b10;

    logic             ex_valid_q, ex_valid_d;
    logic [DW-1:0]    ex_pc_next_q, ex_pc_next_d;
    logic [DW-1:0]    ex_read_data1_q, ex_read_data1_d;
    logic [DW-1:0]    ex_read_data2_q, ex_read_data2_d;
    logic [DW-1:0]    ex_imm_q, ex_imm_d;
    logic [AW-1:0]    ex_rs_q, ex_rs_d;
    logic [AW-1:0]    ex_rt_q, ex_rt_d;
    logic [AW-1:0]    ex_write_addr_q, ex_write_addr_d;
    logic             ex_regwrite_q, ex_regwrite_d;
    logic             ex_memread_q, ex_memread_d;
    logic             ex_memwrite_q, ex_memwrite_d;
    logic [1:0]       ex_memtoreg_q, ex_memtoreg_d;
    logic [3:0]       ex_aluctrl_q, ex_aluctrl_d;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] lu_count_q, lu_count_d;

    logic             lu_hit;
    logic             bubble;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic [DW-1:0]    op_a, op_b;

    // The instruction now in EX is the one that will sit in EX/MEM when the ID instruction executes,
    // so an EX-stage match here becomes select 01 next cycle; a MEM-stage match becomes 10.
    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] src,
        input logic          ex_v,
        input logic          ex_rw,
        input logic [AW-1:0] ex_wa,
        input logic          mem_rw,
        input logic [AW-1:0] mem_wa
    );
        logic [1:0] sel;
        sel = FwdReg;
        if (ex_v && ex_rw && (ex_wa != '0) && (ex_wa == src)) begin
            sel = FwdEx;
        end else if (mem_rw && (mem_wa != '0) && (mem_wa == src)) begin
            sel = FwdMem;
        end
        return sel;
    endfunction

    always_comb begin
        lu_hit = ex_valid_q && ex_memread_q && (ex_write_addr_q != '0) && id_valid &&
                 ((ex_write_addr_q == id_rs) || (ex_write_addr_q == id_rt));
        load_use_stall = lu_hit && !stall_in;
    end

    always_comb begin
        fwd_a_sel = fwd_sel(id_rs, ex_valid_q, ex_regwrite_q, ex_write_addr_q,
                            mem_regwrite, mem_write_addr);
        fwd_b_sel = fwd_sel(id_rt, ex_valid_q, ex_regwrite_q, ex_write_addr_q,
                            mem_regwrite, mem_write_addr);
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        op_a = id_read_data1;
        op_b = id_read_data2;
        if (wb_regwrite && (wb_write_addr != '0) && (wb_write_addr == id_rs)) begin
            op_a = wb_write_data;
        end
        if (wb_regwrite && (wb_write_addr != '0) && (wb_write_addr == id_rt)) begin
            op_b = wb_write_data;
        end
    end
`else
    // Register file is write-before-read, so the WB port is not needed here.
    logic unused_wb;
    assign unused_wb = ^{wb_regwrite, wb_write_addr, wb_write_data};

    always_comb begin
        op_a = id_read_data1;
        op_b = id_read_data2;
    end
`endif

    assign bubble = flush || load_use_stall || !id_valid;

    always_comb begin
        ex_valid_d      = ex_valid_q;
        ex_pc_next_d    = ex_pc_next_q;
        ex_read_data1_d = ex_read_data1_q;
        ex_read_data2_d = ex_read_data2_q;
        ex_imm_d        = ex_imm_q;
        ex_rs_d         = ex_rs_q;
        ex_rt_d         = ex_rt_q;
        ex_write_addr_d = ex_write_addr_q;
        ex_regwrite_d   = ex_regwrite_q;
        ex_memread_d    = ex_memread_q;
        ex_memwrite_d   = ex_memwrite_q;
        ex_memtoreg_d   = ex_memtoreg_q;
        ex_aluctrl_d    = ex_aluctrl_q;
        fwd_a_d         = fwd_a_q;
        fwd_b_d         = fwd_b_q;
        lu_count_d      = lu_count_q;

        if (!stall_in) begin
            if (bubble) begin
                ex_valid_d      = 1'b0;
                ex_pc_next_d    = '0;
                ex_read_data1_d = '0;
                ex_read_data2_d = '0;
                ex_imm_d        = '0;
                ex_rs_d         = '0;
                ex_rt_d         = '0;
                ex_write_addr_d = '0;
                ex_regwrite_d   = 1'b0;
                ex_memread_d    = 1'b0;
                ex_memwrite_d   = 1'b0;
                ex_memtoreg_d   = 2'b00;
                ex_aluctrl_d    = '0;
                fwd_a_d         = FwdReg;
                fwd_b_d         = FwdReg;
            end else begin
                ex_valid_d      = 1'b1;
                ex_pc_next_d    = id_pc_next;
                ex_read_data1_d = op_a;
                ex_read_data2_d = op_b;
                ex_imm_d        = id_imm;
                ex_rs_d         = id_rs;
                ex_rt_d         = id_rt;
                ex_write_addr_d = id_write_addr;
                ex_regwrite_d   = id_regwrite;
                ex_memread_d    = id_memread;
                ex_memwrite_d   = id_memwrite;
                ex_memtoreg_d   = id_memtoreg;
                ex_aluctrl_d    = id_aluctrl;
                fwd_a_d         = fwd_a_sel;
                fwd_b_d         = fwd_b_sel;
            end
            // A flush already supplies the bubble, so it is not counted as a load-use bubble.
            if (load_use_stall && !flush && (lu_count_q != '1)) begin
                lu_count_d = lu_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q      <= 1'b0;
            ex_pc_next_q    <= '0;
            ex_read_data1_q <= '0;
            ex_read_data2_q <= '0;
            ex_imm_q        <= '0;
            ex_rs_q         <= '0;
            ex_rt_q         <= '0;
            ex_write_addr_q <= '0;
            ex_regwrite_q   <= 1'b0;
            ex_memread_q    <= 1'b0;
            ex_memwrite_q   <= 1'b0;
            ex_memtoreg_q   <= 2'b00;
            ex_aluctrl_q    <= '0;
            fwd_a_q         <= FwdReg;
            fwd_b_q         <= FwdReg;
            lu_count_q      <= '0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_pc_next_q    <= ex_pc_next_d;
            ex_read_data1_q <= ex_read_data1_d;
            ex_read_data2_q <= ex_read_data2_d;
            ex_imm_q        <= ex_imm_d;
            ex_rs_q         <= ex_rs_d;
            ex_rt_q         <= ex_rt_d;
            ex_write_addr_q <= ex_write_addr_d;
            ex_regwrite_q   <= ex_regwrite_d;
            ex_memread_q    <= ex_memread_d;
            ex_memwrite_q   <= ex_memwrite_d;
            ex_memtoreg_q   <= ex_memtoreg_d;
            ex_aluctrl_q    <= ex_aluctrl_d;
            fwd_a_q         <= fwd_a_d;
            fwd_b_q         <= fwd_b_d;
            lu_count_q      <= lu_count_d;
        end
    end

    assign ex_valid       = ex_valid_q;
    assign ex_pc_next     = ex_pc_next_q;
    assign ex_read_data1  = ex_read_data1_q;
    assign ex_read_data2  = ex_read_data2_q;
    assign ex_imm         = ex_imm_q;
    assign ex_rs          = ex_rs_q;
    assign ex_rt          = ex_rt_q;
    assign ex_write_addr  = ex_write_addr_q;
    assign ex_regwrite    = ex_regwrite_q;
    assign ex_memread     = ex_memread_q;
    assign ex_memwrite    = ex_memwrite_q;
    assign ex_memtoreg    = ex_memtoreg_q;
    assign ex_aluctrl     = ex_aluctrl_q;
    assign ex_forward_a   = fwd_a_q;
    assign ex_forward_b   = fwd_b_q;
    assign load_use_count = lu_count_q;

endmodule
